// File: rtl/sample_frame_buffer.sv
// sample_frame_buffer: averages ADC samples into a circular frame memory read by the FFT sender.
// Ports: clk/reset (sync, active-high); adc_data/adc_valid raw 12-bit samples in;
// faddr -> fdata registered read port; fhead oldest-sample address (write pointer);
// ready one-cycle new-frame pulse; primed high once the memory has filled since reset.
module sample_frame_buffer #(
    parameter int ADDR_W  = 12,
    parameter int OS_LOG2 = 4,
    parameter int HOP     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       adc_data,
    input  logic              adc_valid,
    input  logic [ADDR_W-1:0] faddr,
    output logic [15:0]       fdata,
    output logic [ADDR_W-1:0] fhead,
    output logic              ready,
    output logic              primed
);
    localparam int AW = 12 + OS_LOG2;
    localparam int CW = OS_LOG2 > 0 ? OS_LOG2 : 1;
    localparam int HW = ADDR_W + 1;

    logic [15:0]       mem [0:(1<<ADDR_W)-1];
    logic [AW-1:0]     acc;
    logic [AW-1:0]     sum;
    logic [CW-1:0]     os_cnt;
    logic [11:0]       avg;
    logic              last;
    logic [15:0]       pend_data;
    logic              pend_we;
    logic [ADDR_W-1:0] wptr;
    logic [HW-1:0]     hop_cnt;

    always_comb begin
        sum  = acc + AW'(adc_data);
        avg  = 12'(sum >> OS_LOG2);
        last = adc_valid && (os_cnt == CW'(2**OS_LOG2 - 1));
    end

    assign fhead = wptr;

    // Memory kept free of reset so it maps onto a simple dual-port block RAM.
    always_ff @(posedge clk) begin
        if (pend_we && !reset)
            mem[wptr] <= pend_data;
    end

    // Read-first: a same-edge write to faddr is not visible until the next read.
    always_ff @(posedge clk) begin
        if (reset)
            fdata <= '0;
        else
            fdata <= mem[faddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            os_cnt    <= '0;
            pend_data <= '0;
            pend_we   <= 1'b0;
            wptr      <= '0;
            hop_cnt   <= '0;
            primed    <= 1'b0;
            ready     <= 1'b0;
        end else begin
            ready   <= 1'b0;
            pend_we <= last;
            if (last) begin
                acc       <= '0;
                os_cnt    <= '0;
                pend_data <= {avg, 4'b0000};
            end else if (adc_valid) begin
                acc    <= sum;
                os_cnt <= os_cnt + CW'(1);
            end
            if (pend_we) begin
                wptr <= wptr + ADDR_W'(1);
                // The wrapping write completes the first full frame and is hop boundary 0.
                if (&wptr && !primed) begin
                    primed  <= 1'b1;
                    ready   <= 1'b1;
                    hop_cnt <= '0;
                end else if (primed) begin
                    if (hop_cnt == HW'(HOP - 1)) begin
                        ready   <= 1'b1;
                        hop_cnt <= '0;
                    end else begin
                        hop_cnt <= hop_cnt + HW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sample_frame_buffer.sv
// tb_sample_frame_buffer: directed checks of averaging, priming, hop pulses, read port and reset.
module tb_sample_frame_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] d2 = '0, d0 = '0;
    logic        v2 = 1'b0, v0 = 1'b0;
    logic [11:0] fa2 = '0, fa0 = '0;
    logic [15:0] fd2, fd0, fd64;
    logic [11:0] fh2, fh0, fh64;
    logic        rd2, rd0, rd64, pr2, pr0, pr64;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sample_frame_buffer #(.ADDR_W(12), .OS_LOG2(2), .HOP(1)) u2 (
        .clk(clk), .reset(reset), .adc_data(d2), .adc_valid(v2), .faddr(fa2),
        .fdata(fd2), .fhead(fh2), .ready(rd2), .primed(pr2));
    sample_frame_buffer #(.ADDR_W(12), .OS_LOG2(0), .HOP(1)) u0 (
        .clk(clk), .reset(reset), .adc_data(d0), .adc_valid(v0), .faddr(fa0),
        .fdata(fd0), .fhead(fh0), .ready(rd0), .primed(pr0));
    sample_frame_buffer #(.ADDR_W(12), .OS_LOG2(0), .HOP(64)) u64 (
        .clk(clk), .reset(reset), .adc_data(d0), .adc_valid(v0), .faddr(fa0),
        .fdata(fd64), .fhead(fh64), .ready(rd64), .primed(pr64));

    typedef struct {
        logic [3:0][11:0] s;
        int               gap;
        logic [15:0]      w;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t tbl[5];
        int early, bad, n0, n64;
        tbl[0] = '{{12'd400, 12'd300, 12'd200, 12'd100}, 0, 16'h0FA0};
        tbl[1] = '{{12'd2, 12'd1, 12'd1, 12'd1}, 0, 16'h0010};
        tbl[2] = '{{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 0, 16'hFFF0};
        tbl[3] = '{{12'h803, 12'h802, 12'h801, 12'h800}, 2, 16'h8010};
        tbl[4] = '{{12'd0, 12'd0, 12'd0, 12'd3}, 0, 16'h0000};

        step();
        step();
        chk("rst_fhead2", fh2, 0);
        chk("rst_fdata2", fd2, 0);
        chk("rst_ready0", rd0, 0);
        chk("rst_primed0", pr0, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) begin
                d2 = tbl[i].s[k];
                v2 = 1'b1;
                step();
                if (tbl[i].gap > 0 && k < 3) begin
                    v2 = 1'b0;
                    repeat (tbl[i].gap) step();
                end
            end
            v2 = 1'b0;
            if (i == 0) chk("fhead_before_write", fh2, 0);
            step();
            chk($sformatf("fhead_vec%0d", i), fh2, i + 1);
            chk($sformatf("ready_vec%0d", i), rd2, 0);
            chk($sformatf("primed_vec%0d", i), pr2, 0);
            fa2 = 12'(i);
            step();
            chk($sformatf("word_vec%0d", i), fd2, tbl[i].w);
        end
        fa2 = 12'd0;
        step();
        chk("word0_kept", fd2, 16'h0FA0);

        early = 0;
        for (int i = 0; i < 4096; i++) begin
            d0 = 12'h800;
            v0 = 1'b1;
            step();
            if (rd0 || pr0) early++;
        end
        v0 = 1'b0;
        chk("no_ready_before_prime", early, 0);
        chk("fhead_pre_wrap", fh0, 12'd4095);
        step();
        chk("prime_ready", rd0, 1);
        chk("prime_primed", pr0, 1);
        chk("prime_fhead", fh0, 0);
        chk("prime_primed64", pr64, 1);
        step();
        chk("prime_ready_1cyc", rd0, 0);
        chk("primed_holds", pr0, 1);

        bad = 0;
        for (int a = 0; a < 4096; a++) begin
            fa0 = 12'(a);
            step();
            if (fd0 !== 16'h8000 || fd64 !== 16'h8000) bad++;
        end
        chk("mem_all_8000", bad, 0);

        fa0 = 12'd0;
        d0 = 12'h123;
        v0 = 1'b1;
        step();
        v0 = 1'b0;
        step();
        chk("post_ready", rd0, 1);
        chk("post_fhead", fh0, 1);
        chk("read_first_old", fd0, 16'h8000);
        step();
        chk("read_new", fd0, 16'h1230);
        chk("post_ready_1cyc", rd0, 0);

        n0 = 0;
        n64 = 0;
        for (int i = 0; i < 130; i++) begin
            d0 = 12'(i);
            v0 = (i < 127);
            step();
            if (rd0) n0++;
            if (rd64) begin
                n64++;
                chk($sformatf("hop_fhead%0d", n64), fh64, 64 * n64);
            end
        end
        v0 = 1'b0;
        chk("hop1_pulses", n0, 127);
        chk("hop64_pulses", n64, 2);

        d2 = 12'd1000;
        v2 = 1'b1;
        step();
        step();
        v2 = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_fdata", fd2, 0);
        chk("midrst_fhead", fh2, 0);
        chk("midrst_primed0", pr0, 0);
        chk("midrst_ready0", rd0, 0);
        chk("midrst_fhead0", fh0, 0);
        chk("midrst_primed64", pr64, 0);
        for (int k = 0; k < 4; k++) begin
            d2 = 12'd8;
            v2 = 1'b1;
            step();
        end
        v2 = 1'b0;
        step();
        chk("after_rst_fhead", fh2, 1);
        fa2 = 12'd0;
        step();
        chk("after_rst_word", fd2, 16'h0080);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sample_frame_buffer.md
Name: sample_frame_buffer

Overview:
- Sits directly upstream of the FFT sender stage.
- Accepts raw 12-bit unsigned ADC samples, averages each group of 2^OS_LOG2 samples into one 16-bit sample, and writes it into a 4096-entry circular sample memory.
- The FFT sender reads that memory through a synchronous read port (faddr -> fdata).
- After the memory first fills, the block pulses ready every HOP written samples. fhead then points at the oldest sample, so a 4096-sample read starting at fhead is in time order.

Parameters:
- ADDR_W, 12, sample memory address width; depth = 2^ADDR_W.
- OS_LOG2, 4, log2 of the oversampling ratio; 16 ADC samples are averaged per stored sample. Legal range 0..8.
- HOP, 1, number of stored samples between ready pulses once primed. Legal range 1..2^ADDR_W.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- adc_data, input, 12, unsigned ADC sample.
- adc_valid, input, 1, adc_data is valid this cycle. Any duty cycle is allowed, including back-to-back.
- faddr, input, ADDR_W, read address.
- fdata, output, 16, registered read data for faddr.
- fhead, output, ADDR_W, write pointer; equals the address of the oldest stored sample.
- ready, output, 1, one-cycle pulse: a new frame is available starting at fhead.
- primed, output, 1, high once 2^ADDR_W samples have been written since reset.

Behaviour:
- Reset (synchronous, wins over all other activity in that cycle):
  - Clears acc, os_cnt, the pending write, wptr/fhead, hop_cnt, primed, ready and fdata.
  - Memory contents are not cleared.
  - A reset mid-accumulation discards the partial group.
- Accumulator:
  - acc width is 12+OS_LOG2 bits, unsigned, cannot overflow.
  - os_cnt width is max(OS_LOG2,1).
  - On a cycle where adc_valid is high and os_cnt < 2^OS_LOG2-1: acc <= acc + adc_data and os_cnt increments.
- Group completion (edge E0): adc_valid is high with os_cnt == 2^OS_LOG2-1.
  - avg = (acc + adc_data) >> OS_LOG2. Truncating floor; 12-bit result.
  - pend_data <= {avg, 4'b0000}, so ADC midscale 0x800 maps to 0x8000, which the consumer treats as signed zero.
  - pend_we <= 1; acc <= 0; os_cnt <= 0.
- Write (edge E1, the edge after E0):
  - mem[wptr] <= pend_data; wptr <= wptr + 1 (wraps modulo 2^ADDR_W).
  - pend_we <= 0, unless a new E0 occurs on the same edge. That is only possible when OS_LOG2 = 0, in which case the pipeline sustains one write per cycle.
  - Samples accepted on E1 go into the new group; there is never a stall or a dropped sample.
- Priming:
  - On the E1 write where wptr wraps from 2^ADDR_W-1 to 0, primed <= 1. primed stays high until reset.
  - ready is never asserted before primed.
- Hop counter:
  - When primed, or becoming primed on this E1, hop_cnt increments on each E1. hop_cnt is cleared when priming occurs.
  - On the E1 where the first post-prime write completes a hop (the priming write itself counts as hop boundary 0), ready <= 1 for exactly one cycle. Thereafter ready fires every HOP writes.
  - While ready is high, fhead already holds the post-write wptr.
- Latency: the final adc_valid of a group at E0 leads to the memory write at E1, with ready/fhead valid in the cycle after E1. That is 2 cycles from E0.
- Read port:
  - fdata <= mem[faddr] on every edge; 1-cycle latency, no enable.
  - A same-address read and write on the same edge returns the old data (read-first).
  - Memory is inferable as simple dual-port block RAM.
- The consumer's read of a frame may overlap ongoing writes. Data older than the next 4096 writes is overwritten by design; no flow control toward the ADC.
- Outputs are driven only from registers.

Test Plan:
- OS_LOG2=2: reset, then adc_valid samples 100, 200, 300, 400 -> mem[0] = 0x0FA0 (avg 250 << 4). fhead=1 two cycles after the 4th valid; ready stays 0; primed=0.
- OS_LOG2=2: samples 1, 1, 1, 2 -> stored 0x0010 (floor 1). Samples 0xFFF ×4 -> stored 0xFFF0; no overflow.
- OS_LOG2=0, HOP=1: 4096 back-to-back valids of value 0x800 -> every mem word = 0x8000. On the final write fhead wraps to 0, primed=1, and ready pulses for exactly 1 cycle, 2 cycles after the last valid. The next valid gives another ready with fhead=1.
- HOP=64, primed: 128 further stored samples -> exactly 2 ready pulses, with fhead=64 then 128. No pulses in between.
- Read timing: write known data, set faddr=5 -> fdata = mem[5] on the next cycle. faddr equal to the address being written on the same edge -> the old value is returned.
- Reset mid-operation: 2 of 4 samples (1000, 1000), then reset, then 4 samples of 8 -> stored {8, 4'b0} = 0x0080 at addr 0. primed=0 and ready=0 after reset even if previously primed.
